// File: rtl/dpram_be.sv
// True dual-port byte-enable word RAM: port A serves instruction fetch, port B load/store.
// Optional post-reset clear, extra output register and write-first read-during-write.
module dpram_be #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DEPTH          = 32,
    parameter bit          OUT_REG        = 1'b0,
    parameter bit          WRITE_FIRST    = 1'b0,
    parameter bit          CLEAR_ON_RESET = 1'b0,
    parameter string       INIT_FILE      = ""
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      a_req,
    input  logic                      a_we,
    input  logic [DATA_WIDTH/8-1:0]   a_be,
    input  logic [ADDR_WIDTH-1:0]     a_addr,
    input  logic [DATA_WIDTH-1:0]     a_wdata,
    output logic                      a_ready,
    output logic                      a_rvalid,
    output logic [DATA_WIDTH-1:0]     a_rdata,
    output logic                      a_err,
    input  logic                      b_req,
    input  logic                      b_we,
    input  logic [DATA_WIDTH/8-1:0]   b_be,
    input  logic [ADDR_WIDTH-1:0]     b_addr,
    input  logic [DATA_WIDTH-1:0]     b_wdata,
    output logic                      b_ready,
    output logic                      b_rvalid,
    output logic [DATA_WIDTH-1:0]     b_rdata,
    output logic                      b_err,
    output logic                      init_done
);
    localparam int unsigned NB  = DATA_WIDTH / 8;
    localparam int unsigned OFF = $clog2(NB);
    localparam int unsigned IW  = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << OFF) - 64'd1);

    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            run_q, run_d;
    logic            clr_we;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Per-port views, index 0 = A, index 1 = B
    logic                  req_w   [2];
    logic                  we_w    [2];
    logic [NB-1:0]         be_w    [2];
    logic [ADDR_WIDTH-1:0] addr_w  [2];
    logic [DATA_WIDTH-1:0] wdata_w [2];

    logic [1:0]            acc, bad, wr;
    logic [ADDR_WIDTH-1:0] widx    [2];
    logic [IW-1:0]         idx     [2];
    logic [DATA_WIDTH-1:0] old     [2];
    logic [DATA_WIDTH-1:0] merged  [2];
    logic [DATA_WIDTH-1:0] resp    [2];

    logic [1:0]            v1_q, e1_q;
    logic [DATA_WIDTH-1:0] d1_q    [2];
    logic [1:0]            rvalid_o, err_o;
    logic [DATA_WIDTH-1:0] rdata_o [2];

    assign req_w[0]   = a_req;    assign req_w[1]   = b_req;
    assign we_w[0]    = a_we;     assign we_w[1]    = b_we;
    assign be_w[0]    = a_be;     assign be_w[1]    = b_be;
    assign addr_w[0]  = a_addr;   assign addr_w[1]  = b_addr;
    assign wdata_w[0] = a_wdata;  assign wdata_w[1] = b_wdata;

    // Init/run sequencer: optional one-word-per-cycle clear before the ports open
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        case (state_q)
            S_INIT: begin
                if (CLEAR_ON_RESET) begin
                    clr_we    = 1'b1;
                    clr_cnt_d = clr_cnt_q + IW'(1);
                    if (clr_cnt_q == IW'(DEPTH - 1)) begin
                        state_d   = S_RUN;
                        clr_cnt_d = '0;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN:   state_d = S_RUN;
            default: state_d = S_INIT;
        endcase
        run_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_INIT;
            clr_cnt_q <= '0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            run_q     <= run_d;
        end
    end

    // Address decode, error detection and response word selection
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            acc[p]  = req_w[p] & run_q;
            widx[p] = addr_w[p] >> OFF;
            bad[p]  = (|(addr_w[p] & ALIGN_MASK)) | (64'(widx[p]) >= 64'(DEPTH));
            idx[p]  = IW'(widx[p]);
            old[p]  = mem[idx[p]];
            wr[p]   = acc[p] & we_w[p] & ~bad[p];
            merged[p] = old[p];
            for (int b = 0; b < NB; b++) begin
                if (be_w[p][b]) merged[p][8*b +: 8] = wdata_w[p][8*b +: 8];
            end
            if (bad[p])                      resp[p] = '0;
            else if (we_w[p] && WRITE_FIRST) resp[p] = merged[p];
            else                             resp[p] = old[p];
        end
    end

    // Port B is applied last so it owns bytes both ports enable on a shared word
    always_ff @(posedge clk) begin
        if (clr_we) mem[clr_cnt_q] <= '0;
        for (int p = 0; p < 2; p++) begin
            if (wr[p]) begin
                for (int b = 0; b < NB; b++) begin
                    if (be_w[p][b]) mem[idx[p]][8*b +: 8] <= wdata_w[p][8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= '0;
            e1_q    <= '0;
            d1_q[0] <= '0;
            d1_q[1] <= '0;
        end else begin
            v1_q <= acc;
            e1_q <= acc & bad;
            for (int p = 0; p < 2; p++) begin
                d1_q[p] <= acc[p] ? resp[p] : '0;
            end
        end
    end

    if (OUT_REG) begin : g_out_reg
        logic [1:0]            v2_q, e2_q;
        logic [DATA_WIDTH-1:0] d2_q [2];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v2_q    <= '0;
                e2_q    <= '0;
                d2_q[0] <= '0;
                d2_q[1] <= '0;
            end else begin
                v2_q    <= v1_q;
                e2_q    <= e1_q;
                d2_q[0] <= d1_q[0];
                d2_q[1] <= d1_q[1];
            end
        end

        assign rvalid_o   = v2_q;
        assign err_o      = e2_q;
        assign rdata_o[0] = d2_q[0];
        assign rdata_o[1] = d2_q[1];
    end else begin : g_out_direct
        assign rvalid_o   = v1_q;
        assign err_o      = e1_q;
        assign rdata_o[0] = d1_q[0];
        assign rdata_o[1] = d1_q[1];
    end

    assign a_ready   = run_q;
    assign b_ready   = run_q;
    assign init_done = run_q;
    assign a_rvalid  = rvalid_o[0];
    assign b_rvalid  = rvalid_o[1];
    assign a_err     = err_o[0];
    assign b_err     = err_o[1];
    assign a_rdata   = rdata_o[0];
    assign b_rdata   = rdata_o[1];

endmodule
